// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - per-channel result FIFOs merged by a round-robin arbiter into one writeback port
module writeback_arbiter #(
    parameter int XLEN  = 64,
    parameter int NCH   = 2,
    parameter int DEPTH = 4,
    parameter int CST_W = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [NCH-1:0]       WB_V,
    output logic [NCH-1:0]       WB_READY,
    input  logic [NCH*CST_W-1:0] WB_Cst,
    input  logic [NCH*XLEN-1:0]  WB_RES,
    input  logic [NCH-1:0]       WB_PC_MUX,
    input  logic [NCH*32-1:0]    WB_IR,
    input  logic [NCH*XLEN-1:0]  WB_Target_Address,
    output logic [XLEN-1:0]      OUT_FE_Target_Address,
    output logic                 OUT_FE_PC_MUX,
    output logic                 OUT_FE_REG_WEN,
    output logic [4:0]           OUT_DE_DR,
    output logic [XLEN-1:0]      OUT_DE_Data,
    output logic [63:0]          OUT_RETIRE_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef struct packed {
        logic [CST_W-1:0] cst;
        logic [XLEN-1:0]  res;
        logic             pc_mux;
        logic [31:0]      ir;
        logic [XLEN-1:0]  tgt;
    } entry_t;

    entry_t           mem_q [NCH][DEPTH];
    entry_t           mem_d [NCH][DEPTH];
    entry_t           in_ent [NCH];
    logic [PW-1:0]    wr_q [NCH];
    logic [PW-1:0]    wr_d [NCH];
    logic [PW-1:0]    rd_q [NCH];
    logic [PW-1:0]    rd_d [NCH];
    logic [CW-1:0]    rr_q, rr_d;
    logic             wen_q, wen_d, pcm_q, pcm_d;
    logic [4:0]       dr_q, dr_d;
    logic [XLEN-1:0]  data_q, data_d, tgt_q, tgt_d;
    logic [63:0]      cnt_q, cnt_d;

    logic [NCH-1:0]   empty, full;
    logic             sel_v, flush;
    logic [CW-1:0]    sel, idx;
    entry_t           head;
    logic             unused_head;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            in_ent[i].cst    = WB_Cst[i*CST_W +: CST_W];
            in_ent[i].res    = WB_RES[i*XLEN +: XLEN];
            in_ent[i].pc_mux = WB_PC_MUX[i];
            in_ent[i].ir     = WB_IR[i*32 +: 32];
            in_ent[i].tgt    = WB_Target_Address[i*XLEN +: XLEN];
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < NCH; i++) begin
            empty[i] = (wr_q[i] == rd_q[i]);
            full[i]  = (wr_q[i][AW] != rd_q[i][AW]) && (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]);
        end
    end

    assign WB_READY = ~full;

    always_comb begin
        sel_v = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = CW'((int'(rr_q) + k) % NCH);
            if (!sel_v && !empty[idx]) begin
                sel_v = 1'b1;
                sel   = idx;
            end
        end
    end

    assign head        = mem_q[sel][rd_q[sel][AW-1:0]];
    assign flush       = sel_v && head.pc_mux;
    assign unused_head = ^{head.cst, head.ir};

    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        rr_d   = rr_q;
        wen_d  = 1'b0;
        pcm_d  = 1'b0;
        dr_d   = dr_q;
        data_d = data_q;
        tgt_d  = tgt_q;
        cnt_d  = cnt_q;
        if (sel_v) begin
            rd_d[sel] = rd_q[sel] + PW'(1);
            rr_d      = (sel == CW'(NCH - 1)) ? '0 : sel + CW'(1);
            wen_d     = head.cst[0] && (head.ir[11:7] != 5'd0);
            pcm_d     = head.pc_mux;
            dr_d      = head.ir[11:7];
            data_d    = head.res;
            tgt_d     = head.tgt;
            cnt_d     = cnt_q + 64'd1;
        end
        for (int i = 0; i < NCH; i++) begin
            if (WB_V[i] && !full[i] && !flush) begin
                mem_d[i][wr_q[i][AW-1:0]] = in_ent[i];
                wr_d[i] = wr_q[i] + PW'(1);
            end
            // A redirect discards everything still buffered behind it.
            if (flush) begin
                rd_d[i] = wr_q[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NCH; i++) begin
                wr_q[i] <= '0;
                rd_q[i] <= '0;
            end
            rr_q   <= '0;
            wen_q  <= 1'b0;
            pcm_q  <= 1'b0;
            dr_q   <= '0;
            data_q <= '0;
            tgt_q  <= '0;
            cnt_q  <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            rr_q   <= rr_d;
            wen_q  <= wen_d;
            pcm_q  <= pcm_d;
            dr_q   <= dr_d;
            data_q <= data_d;
            tgt_q  <= tgt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign OUT_FE_Target_Address = tgt_q;
    assign OUT_FE_PC_MUX         = pcm_q;
    assign OUT_FE_REG_WEN        = wen_q;
    assign OUT_DE_DR             = dr_q;
    assign OUT_DE_Data           = data_q;
    assign OUT_RETIRE_CNT        = cnt_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - randomized and directed bench for writeback_arbiter against a queue model
module tb_writeback_arbiter;

    localparam int XLEN  = 64;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int CST_W = 4;

    typedef struct packed {
        logic [3:0]  cst;
        logic [63:0] res;
        logic        pcm;
        logic [31:0] ir;
        logic [63:0] tgt;
    } ent_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NCH-1:0]       wb_v = '0;
    logic [NCH-1:0]       wb_ready;
    logic [NCH*CST_W-1:0] wb_cst = '0;
    logic [NCH*XLEN-1:0]  wb_res = '0;
    logic [NCH-1:0]       wb_pcm = '0;
    logic [NCH*32-1:0]    wb_ir = '0;
    logic [NCH*XLEN-1:0]  wb_tgt = '0;
    logic [XLEN-1:0]      o_tgt, o_data;
    logic                 o_pcm, o_wen;
    logic [4:0]           o_dr;
    logic [63:0]          o_cnt;

    writeback_arbiter #(.XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH), .CST_W(CST_W)) dut (
        .CLK(clk), .RESET_N(rst_n), .WB_V(wb_v), .WB_READY(wb_ready),
        .WB_Cst(wb_cst), .WB_RES(wb_res), .WB_PC_MUX(wb_pcm), .WB_IR(wb_ir),
        .WB_Target_Address(wb_tgt), .OUT_FE_Target_Address(o_tgt),
        .OUT_FE_PC_MUX(o_pcm), .OUT_FE_REG_WEN(o_wen), .OUT_DE_DR(o_dr),
        .OUT_DE_Data(o_data), .OUT_RETIRE_CNT(o_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ent_t           mq [NCH][$];
    int             rr_m;
    logic           e_wen, e_pcm;
    logic [4:0]     e_dr;
    logic [63:0]    e_data, e_tgt, e_cnt;
    logic [NCH-1:0] acc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) mq[i].delete();
        rr_m = 0; e_wen = 0; e_pcm = 0; e_dr = 0; e_data = 0; e_tgt = 0; e_cnt = 0; acc = '0;
    endtask

    function automatic ent_t cur_ent(input int i);
        ent_t e;
        e.cst = wb_cst[i*CST_W +: CST_W];
        e.res = wb_res[i*XLEN +: XLEN];
        e.pcm = wb_pcm[i];
        e.ir  = wb_ir[i*32 +: 32];
        e.tgt = wb_tgt[i*XLEN +: XLEN];
        return e;
    endfunction

    // Spec-level retirement: oldest entry of the first non-empty channel from the RR pointer.
    task automatic model_step();
        bit rdy [NCH];
        int sel;
        bit flush;
        ent_t e;
        for (int i = 0; i < NCH; i++) rdy[i] = (mq[i].size() < DEPTH);
        sel = -1;
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (rr_m + k) % NCH;
            if (sel < 0 && mq[c].size() > 0) sel = c;
        end
        flush = 0; e_wen = 0; e_pcm = 0;
        if (sel >= 0) begin
            e = mq[sel].pop_front();
            e_wen  = e.cst[0] && (e.ir[11:7] != 5'd0);
            e_pcm  = e.pcm;
            e_dr   = e.ir[11:7];
            e_data = e.res;
            e_tgt  = e.tgt;
            e_cnt  = e_cnt + 64'd1;
            rr_m   = (sel + 1) % NCH;
            flush  = e.pcm;
        end
        for (int i = 0; i < NCH; i++) begin
            acc[i] = wb_v[i] && rdy[i];
            if (acc[i] && !flush) mq[i].push_back(cur_ent(i));
        end
        if (flush) for (int i = 0; i < NCH; i++) mq[i].delete();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_ch(input int i, input bit v, input logic [3:0] cst, input logic [4:0] dr,
                          input logic [63:0] res, input bit pcm, input logic [63:0] tgt);
        logic [31:0] ir;
        ir = $urandom();
        ir[11:7] = dr;
        wb_v[i] = v;
        wb_cst[i*CST_W +: CST_W] = cst;
        wb_res[i*XLEN +: XLEN] = res;
        wb_pcm[i] = pcm;
        wb_ir[i*32 +: 32] = ir;
        wb_tgt[i*XLEN +: XLEN] = tgt;
    endtask

    // Producers hold an unaccepted request; otherwise present fresh data.
    task automatic produce(input bit flood);
        for (int i = 0; i < NCH; i++) begin
            if (!(wb_v[i] && !acc[i])) begin
                if (flood)
                    set_ch(i, 1'b1, 4'($urandom()), 5'($urandom()), {$urandom(), $urandom()}, 1'b0,
                           {$urandom(), $urandom()});
                else
                    set_ch(i, 1'($urandom_range(0, 1)), 4'($urandom()), 5'($urandom()),
                           {$urandom(), $urandom()}, ($urandom_range(0, 11) == 0),
                           {$urandom(), $urandom()});
            end
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [NCH-1:0] er;
        if (chk_en) begin
            for (int i = 0; i < NCH; i++) er[i] = (mq[i].size() < DEPTH);
            chk("reg_wen", 64'(o_wen), 64'(e_wen));
            chk("pc_mux", 64'(o_pcm), 64'(e_pcm));
            chk("dr", 64'(o_dr), 64'(e_dr));
            chk("data", o_data, e_data);
            chk("target", o_tgt, e_tgt);
            chk("retire_cnt", o_cnt, e_cnt);
            chk("wb_ready", 64'(wb_ready), 64'(er));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw_full;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wen", 64'(o_wen), 64'd0);
        chk("rst_pcm", 64'(o_pcm), 64'd0);
        chk("rst_cnt", o_cnt, 64'd0);
        chk("rst_data", o_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();
        chk("ready_after_rst", 64'(wb_ready), 64'h3);

        // Single entry on ch0
        set_ch(0, 1'b1, 4'h1, 5'd5, 64'hDEAD_BEEF, 1'b0, 64'h0);
        tick();
        wb_v = '0;
        tick();
        chk("se_wen", 64'(o_wen), 64'd1);
        chk("se_dr", 64'(o_dr), 64'd5);
        chk("se_data", o_data, 64'hDEAD_BEEF);
        tick();
        chk("se_wen_off", 64'(o_wen), 64'd0);
        chk("se_cnt", o_cnt, 64'd1);

        // x0 write suppressed on ch1; also returns the RR pointer to ch0
        set_ch(1, 1'b1, 4'h1, 5'd0, 64'h1234, 1'b0, 64'h0);
        tick();
        wb_v = '0;
        tick();
        chk("x0_wen", 64'(o_wen), 64'd0);
        chk("x0_cnt", o_cnt, 64'd2);

        // Round robin A0,B0,A1,B1
        set_ch(0, 1'b1, 4'h1, 5'd1, 64'hA0, 1'b0, 64'h0);
        set_ch(1, 1'b1, 4'h1, 5'd2, 64'hB0, 1'b0, 64'h0);
        tick();
        set_ch(0, 1'b1, 4'h1, 5'd3, 64'hA1, 1'b0, 64'h0);
        set_ch(1, 1'b1, 4'h1, 5'd4, 64'hB1, 1'b0, 64'h0);
        tick();
        chk("rr_0", 64'(o_dr), 64'd1);
        wb_v = '0;
        tick();
        chk("rr_1", 64'(o_dr), 64'd2);
        tick();
        chk("rr_2", 64'(o_dr), 64'd3);
        tick();
        chk("rr_3", 64'(o_dr), 64'd4);
        chk("rr_cnt", o_cnt, 64'd6);

        // Redirect flush: ch0 head redirects while ch1 holds 3 entries and pushes
        set_ch(0, 1'b1, 4'h1, 5'd10, 64'h10, 1'b0, 64'h0);
        set_ch(1, 1'b1, 4'h1, 5'd20, 64'h20, 1'b0, 64'h0);
        tick();
        set_ch(0, 1'b1, 4'h1, 5'd11, 64'h11, 1'b0, 64'h0);
        set_ch(1, 1'b1, 4'h1, 5'd21, 64'h21, 1'b0, 64'h0);
        tick();
        wb_v[0] = 1'b0;
        set_ch(1, 1'b1, 4'h1, 5'd22, 64'h22, 1'b0, 64'h0);
        tick();
        set_ch(0, 1'b1, 4'h1, 5'd7, 64'h77, 1'b1, 64'h8000_0040);
        set_ch(1, 1'b1, 4'h1, 5'd23, 64'h23, 1'b0, 64'h0);
        tick();
        wb_v[0] = 1'b0;
        set_ch(1, 1'b1, 4'h1, 5'd24, 64'h24, 1'b0, 64'h0);
        tick();
        set_ch(1, 1'b1, 4'h1, 5'd25, 64'h25, 1'b0, 64'h0);
        tick();
        chk("fl_pcm", 64'(o_pcm), 64'd1);
        chk("fl_tgt", o_tgt, 64'h8000_0040);
        chk("fl_dr", 64'(o_dr), 64'd7);
        chk("fl_wen", 64'(o_wen), 64'd1);
        chk("fl_cnt", o_cnt, 64'd11);
        wb_v = '0;
        tick();
        chk("fl_pcm_off", 64'(o_pcm), 64'd0);
        chk("fl_ready", 64'(wb_ready), 64'h3);
        tick();
        chk("fl_no_retire_wen", 64'(o_wen), 64'd0);
        chk("fl_no_retire_cnt", o_cnt, 64'd11);

        // Backpressure: both channels flood
        saw_full = 1'b0;
        for (int c = 0; c < 30; c++) begin
            produce(1'b1);
            tick();
            if (!wb_ready[1]) saw_full = 1'b1;
        end
        chk("bp_ready1_drop", 64'(saw_full), 64'd1);

        // Random traffic with occasional redirects
        for (int c = 0; c < 500; c++) begin
            produce(1'b0);
            tick();
        end

        // Reset mid-stream
        for (int c = 0; c < 6; c++) begin
            produce(1'b1);
            tick();
        end
        #2;
        rst_n = 1'b0;
        chk_en = 1'b0;
        #1;
        chk("mid_rst_wen", 64'(o_wen), 64'd0);
        chk("mid_rst_pcm", 64'(o_pcm), 64'd0);
        chk("mid_rst_dr", 64'(o_dr), 64'd0);
        chk("mid_rst_data", o_data, 64'd0);
        chk("mid_rst_tgt", o_tgt, 64'd0);
        chk("mid_rst_cnt", o_cnt, 64'd0);
        wb_v = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (6) tick();
        chk("post_rst_cnt", o_cnt, 64'd0);
        chk("post_rst_wen", 64'(o_wen), 64'd0);
        chk("post_rst_ready", 64'(wb_ready), 64'h3);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
Parametrised writeback stage that merges NCH independent result channels into the single register-file write port and the fetch redirect path. Possible channels are ALU, MUL/DIV and load. Each channel has a DEPTH-entry FIFO with ready/valid backpressure. A round-robin arbiter retires one entry per cycle. A retired redirect flushes all buffered results. Outputs are registered and drive fetch (redirect, regfile write enable) and decode (DR, data) directly.

Parameters:
XLEN, 64, data/address width
NCH, 2, number of result channels (1..8)
DEPTH, 4, entries per channel FIFO; power of two, >=2
CST_W, 4, control-store width; bit 0 = register write enable

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
WB_V  in  NCH  per-channel valid
WB_READY  out  NCH  per-channel ready; high when that FIFO is not full
WB_Cst  in  NCH*CST_W  per-channel control bits, channel i at [i*CST_W +: CST_W]
WB_RES  in  NCH*XLEN  per-channel result
WB_PC_MUX  in  NCH  per-channel redirect request
WB_IR  in  NCH*32  per-channel instruction; DR = IR[11:7]
WB_Target_Address  in  NCH*XLEN  per-channel redirect target
OUT_FE_Target_Address  out  XLEN  redirect target
OUT_FE_PC_MUX  out  1  redirect strobe, one cycle
OUT_FE_REG_WEN  out  1  regfile write enable, one cycle
OUT_DE_DR  out  5  destination register
OUT_DE_Data  out  XLEN  write data
OUT_RETIRE_CNT  out  64  retired-entry counter

Behaviour:
- Reset (async assert, sync deassert on CLK):
  - all FIFOs empty, pointers 0
  - round-robin pointer = 0, so channel 0 has top priority first
  - all OUT_* = 0; OUT_RETIRE_CNT = 0
  - WB_READY all 1 from the first cycle after deassert
- Enqueue:
  - channel i pushes {Cst, RES, PC_MUX, IR, Target} on a rising edge when WB_V[i] && WB_READY[i]
  - WB_READY[i] = !full[i], with no combinational dependence on pop
  - a full FIFO refuses a push even in a cycle it pops
  - WB_V while not ready is held off by the producer; no drop or overwrite
- Arbitration:
  - each cycle, select the first non-empty channel scanning from the RR pointer upward, wrapping modulo NCH
  - pop the selected channel; RR pointer = selected+1 mod NCH
  - no non-empty channel: no pop, pointer unchanged
- Latency:
  - entry pushed at edge N is visible at FIFO head after N; earliest retirement registers outputs at edge N+1
  - empty-to-output latency is 1 cycle
- Output register, loaded on every edge:
  - popped entry:
    - OUT_FE_REG_WEN = Cst[0] && (DR != 0); writes to x0 are suppressed
    - OUT_DE_DR = IR[11:7]
    - OUT_DE_Data = RES
    - OUT_FE_PC_MUX = PC_MUX
    - OUT_FE_Target_Address = Target
  - no pop: OUT_FE_REG_WEN = 0 and OUT_FE_PC_MUX = 0; DR, Data and Target hold their last value
- Retire counter:
  - increments by 1 per pop, including entries with write enable 0 or DR = 0
  - wraps 2^64-1 -> 0
- Redirect flush: when the popped entry has PC_MUX = 1, on the same edge
  - all FIFOs are emptied, including remaining entries of the popping channel
  - any push in that cycle is discarded, and WB_READY stays 1 that cycle
  - the RR pointer still advances
  - the popped entry itself retires normally, and its register write still happens
- Pointer wrap: rd/wr pointers are log2(DEPTH)+1 bits
  - full = MSBs differ and low bits equal
  - empty = pointers equal
- Simultaneous push and pop on the same non-full channel: both occur; occupancy unchanged.

Test Plan:
- Reset mid-stream:
  - 3 entries queued in ch0, assert RESET_N=0 asynchronously
  - all OUT_* and OUT_RETIRE_CNT go 0 immediately, WB_READY=2'b11 after release
  - no queued entry retires afterwards
- Single entry:
  - ch0 pushes IR DR=5, RES=64'hDEAD_BEEF, Cst=4'h1 at edge N
  - at edge N+1: REG_WEN=1, DR=5, Data=DEAD_BEEF; at N+2: REG_WEN=0, RETIRE_CNT=1
- Round-robin:
  - both channels hold 2 entries (A0,A1 / B0,B1)
  - retire order A0,B0,A1,B1 on 4 consecutive edges, RETIRE_CNT=4
- x0 suppression:
  - entry with Cst[0]=1, DR=0
  - REG_WEN=0, RETIRE_CNT increments
- Backpressure:
  - hold ch1 WB_V=1 for 6 cycles, DEPTH=4, while ch0 floods so ch1 gets ~half the grants
  - WB_READY[1] drops when 4 entries are held; no entry is lost or duplicated (scoreboard)
- Redirect flush:
  - ch0 head has PC_MUX=1, Target=64'h8000_0040; ch1 holds 3 entries and pushes on the same cycle
  - OUT_FE_PC_MUX=1 for one cycle with Target 0x8000_0040
  - all FIFOs empty next cycle; the ch1 entries and the same-cycle push never retire
